// File: rtl/ro_edge_counter_avg.sv
`timescale 1ns/1ps
// Ring-oscillator edge counter: counts synchronized OSC_OUT rising edges per
// COUNT_DONE-delimited window and averages 2^AVG_LOG2 windows into COUNTER.
module ro_edge_counter_avg #(
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       OSC_OUT,
    input  logic       ENABLE,
    input  logic       COUNT_DONE,
    input  logic       FORCE_RST,
    output logic [7:0] COUNTER,
    output logic       COUNTER_VALID,
    output logic       OVERFLOW
);

    localparam int ACC_W = 8 + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   osc_edge;

    logic [7:0]       win_cnt;
    logic [7:0]       win_next;
    logic             win_full;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_next;
    logic [IDX_W-1:0] idx;
    logic             measuring;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // update from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], OSC_OUT};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign osc_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Window value including the current-cycle edge, so a coincident edge
    // lands in the closing window.
    always_comb begin
        win_full  = (win_cnt == 8'hFF);
        win_next  = (osc_edge && !win_full) ? win_cnt + 8'd1 : win_cnt;
        sum_next  = acc + ACC_W'(win_next);
        measuring = (state_q == MEASURE) && ENABLE && !FORCE_RST;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state is defaulted first so no path through the case leaves
    // state_d unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        if (FORCE_RST) begin
            state_d = ENABLE ? ARM : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (ENABLE) state_d = ARM;
                ARM: begin
                    if (!ENABLE)         state_d = IDLE;
                    else if (COUNT_DONE) state_d = MEASURE;
                end
                MEASURE: if (!ENABLE) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            win_cnt       <= '0;
            acc           <= '0;
            idx           <= '0;
            COUNTER       <= '0;
            COUNTER_VALID <= 1'b0;
            OVERFLOW      <= 1'b0;
        end else begin
            COUNTER_VALID <= 1'b0;
            if (FORCE_RST) begin
                win_cnt  <= '0;
                acc      <= '0;
                idx      <= '0;
                OVERFLOW <= 1'b0;
            end else if (measuring) begin
                if (osc_edge && win_full) begin
                    OVERFLOW <= 1'b1;
                end
                if (COUNT_DONE) begin
                    win_cnt <= '0;
                    if (idx == IDX_LAST) begin
                        COUNTER       <= 8'(sum_next >> AVG_LOG2);
                        COUNTER_VALID <= 1'b1;
                        acc           <= '0;
                        idx           <= '0;
                    end else begin
                        acc <= sum_next;
                        idx <= idx + 1'b1;
                    end
                end else begin
                    win_cnt <= win_next;
                end
            end else begin
                // IDLE, ARM or just disabled: partial window and sum are dropped.
                win_cnt <= '0;
                acc     <= '0;
                idx     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ro_edge_counter_avg.sv
`timescale 1ns/1ps
// Directed bench: one averaging instance (AVG_LOG2=2) and one pass-through
// instance (AVG_LOG2=0) share all stimulus; windows are table driven.
module tb_ro_edge_counter_avg;

    logic       clk = 1'b0;
    logic       rst;
    logic       osc_out;
    logic       enable;
    logic       count_done;
    logic       force_rst;
    logic [7:0] counter_avg, counter_raw;
    logic       valid_avg, valid_raw;
    logic       ovf_avg, ovf_raw;

    int n_cmp = 0;
    int n_fail = 0;
    int valid_raw_cnt = 0;
    int snap;

    typedef struct {
        int   n_edges;
        int   len;
        int   raw_cnt;
        logic avg_valid;
        int   avg_cnt;
        logic ovf;
    } win_vec_t;

    win_vec_t vecs [12];

    ro_edge_counter_avg #(.AVG_LOG2(2), .SYNC_STAGES(2)) dut_avg (
        .CLK(clk), .RST(rst), .OSC_OUT(osc_out), .ENABLE(enable),
        .COUNT_DONE(count_done), .FORCE_RST(force_rst),
        .COUNTER(counter_avg), .COUNTER_VALID(valid_avg), .OVERFLOW(ovf_avg)
    );

    ro_edge_counter_avg #(.AVG_LOG2(0), .SYNC_STAGES(2)) dut_raw (
        .CLK(clk), .RST(rst), .OSC_OUT(osc_out), .ENABLE(enable),
        .COUNT_DONE(count_done), .FORCE_RST(force_rst),
        .COUNTER(counter_raw), .COUNTER_VALID(valid_raw), .OVERFLOW(ovf_raw)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_raw === 1'b1) valid_raw_cnt <= valid_raw_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 ns after the sampling edge.
    task automatic cyc(input logic osc, input logic done);
        osc_out    = osc;
        count_done = done;
        @(posedge clk);
        #1;
    endtask

    // n edges (period 4) all registered by the last cycle, COUNT_DONE on the last cycle.
    task automatic run_window(input int n, input int len);
        for (int c = 0; c < len; c++) begin
            cyc((c < 4 * n) && ((c % 4) >= 2), c == len - 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded 2000000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // n, len, raw COUNTER, avg valid, avg COUNTER, OVERFLOW
        vecs[0]  = '{10,   60,  10, 1'b0,   0, 1'b0};
        vecs[1]  = '{11,   60,  11, 1'b0,   0, 1'b0};
        vecs[2]  = '{11,   60,  11, 1'b0,   0, 1'b0};
        vecs[3]  = '{11,   60,  11, 1'b1,  10, 1'b0};  // 43 >> 2
        vecs[4]  = '{30,  121,  30, 1'b0,  10, 1'b0};  // 30th edge on the COUNT_DONE cycle
        vecs[5]  = '{5,    40,   5, 1'b0,  10, 1'b0};
        vecs[6]  = '{0,    10,   0, 1'b0,  10, 1'b0};
        vecs[7]  = '{1,    10,   1, 1'b1,   9, 1'b0};  // 36 >> 2
        vecs[8]  = '{255, 1021, 255, 1'b0,  9, 1'b0};  // exactly full, no overflow
        vecs[9]  = '{300, 1201, 255, 1'b0,  9, 1'b1};
        vecs[10] = '{20,   90,  20, 1'b0,   9, 1'b1};
        vecs[11] = '{3,    20,   3, 1'b1, 133, 1'b1};  // 533 >> 2

        rst = 1'b1; osc_out = 1'b0; enable = 1'b0; count_done = 1'b0; force_rst = 1'b0;
        #12;
        check("reset avg counter", counter_avg, 0);
        check("reset raw counter", counter_raw, 0);
        check("reset raw valid", valid_raw, 0);
        check("reset raw overflow", ovf_raw, 0);
        check("reset avg overflow", ovf_avg, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(1'b0, 1'b1);
        check("idle ignores done", valid_raw, 0);
        enable = 1'b1;
        cyc(1'b0, 1'b0);
        run_window(4, 30);
        check("arm window raw valid", valid_raw, 0);
        check("arm window raw counter", counter_raw, 0);

        for (int i = 0; i < 12; i++) begin
            run_window(vecs[i].n_edges, vecs[i].len);
            check($sformatf("w%0d raw counter", i), counter_raw, vecs[i].raw_cnt);
            check($sformatf("w%0d raw valid", i), valid_raw, 1);
            check($sformatf("w%0d avg valid", i), valid_avg, vecs[i].avg_valid);
            check($sformatf("w%0d avg counter", i), counter_avg, vecs[i].avg_cnt);
            check($sformatf("w%0d raw overflow", i), ovf_raw, vecs[i].ovf);
            check($sformatf("w%0d avg overflow", i), ovf_avg, vecs[i].ovf);
            cyc(1'b0, 1'b0);
            check($sformatf("w%0d raw valid pulse", i), valid_raw, 0);
            check($sformatf("w%0d avg valid pulse", i), valid_avg, 0);
        end

        // Continuous oscillator, period 8, COUNT_DONE every 400 cycles.
        for (int c = 0; c < 1600; c++) begin
            cyc((c % 8) >= 4, (c % 400) == 399);
            if ((c % 400) == 399) begin
                check($sformatf("avg8 win%0d raw counter", c / 400), counter_raw, 50);
                check($sformatf("avg8 win%0d avg valid", c / 400), valid_avg, (c == 1599) ? 1 : 0);
                check($sformatf("avg8 win%0d avg counter", c / 400), counter_avg, (c == 1599) ? 50 : 133);
                check($sformatf("avg8 win%0d overflow sticky", c / 400), ovf_raw, 1);
            end
        end

        // Saturate, then FORCE_RST together with COUNT_DONE.
        run_window(300, 1201);
        check("sat raw counter", counter_raw, 255);
        check("sat raw overflow", ovf_raw, 1);
        force_rst = 1'b1;
        cyc(1'b0, 1'b1);
        force_rst = 1'b0;
        check("force overflow cleared", ovf_raw, 0);
        check("force avg overflow cleared", ovf_avg, 0);
        check("force raw valid", valid_raw, 0);
        check("force raw counter held", counter_raw, 255);
        check("force avg counter held", counter_avg, 50);
        run_window(8, 40);
        check("force rearm raw valid", valid_raw, 0);
        check("force rearm raw counter", counter_raw, 255);
        run_window(12, 60);
        check("post force raw counter", counter_raw, 12);
        check("post force raw valid", valid_raw, 1);
        check("post force overflow", ovf_raw, 0);

        // Disable mid-window (with a coincident COUNT_DONE) and restart.
        cyc(1'b0, 1'b0);
        snap = valid_raw_cnt;
        for (int c = 0; c < 20; c++) cyc((c % 4) >= 2, 1'b0);
        enable = 1'b0;
        cyc(1'b0, 1'b1);
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1);
        check("disable valid pulses", valid_raw_cnt - snap, 0);
        check("disable raw counter held", counter_raw, 12);
        check("disable avg counter held", counter_avg, 50);
        enable = 1'b1;
        cyc(1'b0, 1'b0);
        run_window(9, 40);
        check("restart arm raw valid", valid_raw, 0);
        check("restart arm valid pulses", valid_raw_cnt - snap, 0);
        check("restart arm raw counter", counter_raw, 12);
        run_window(4, 20);
        check("restart raw counter", counter_raw, 4);
        check("restart raw valid", valid_raw, 1);

        // Asynchronous reset mid-window.
        for (int c = 0; c < 10; c++) cyc((c % 4) >= 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst raw counter", counter_raw, 0);
        check("async rst avg counter", counter_avg, 0);
        check("async rst raw valid", valid_raw, 0);
        check("async rst overflow", ovf_raw, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        run_window(7, 40);
        check("post rst arm raw valid", valid_raw, 0);
        check("post rst arm raw counter", counter_raw, 0);
        run_window(6, 30);
        check("post rst raw counter", counter_raw, 6);
        check("post rst raw valid", valid_raw, 1);
        check("post rst avg valid", valid_avg, 0);
        cyc(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
